// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: one command in flight, registered APB and response outputs.
// Optional ACCESS wait timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int PDATA_SIZE     = 32,
    parameter int PADDR_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // SETUP  | PSEL high, PENABLE low, one cycle only
    // ACCESS | PSEL and PENABLE high until PREADY (or timeout)
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state_q, state_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [PDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  timeout;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == SETUP) begin
            wait_cnt_d = '0;
        end else if (state_q == ACCESS && !PREADY) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ACCESS) && !PREADY && (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid && cmd_ready_q) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (state_q == IDLE && state_d == SETUP) begin
            // read commands put zero on the write-only buses
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_strb : '0;
        end
        if (state_q == ACCESS && state_d == IDLE) begin
            rsp_valid_d = 1'b1;
            if (PREADY) begin
                rsp_err_d   = PSLVERR;
                rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            end else begin
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: random commands against an APB slave model with a response scoreboard.
// Timeout expectations follow APB_TIMEOUT_EN when it is defined for the build.
module tb_apb_cmd_master;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_cmd_master #(.PDATA_SIZE(DW), .PADDR_SIZE(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          write;
        bit [AW-1:0] addr;
        bit [DW-1:0] wdata;
        bit [SW-1:0] strb;
        int          waits;
        bit [DW-1:0] prdata;
        bit          err;
    } txn_t;

    typedef struct {
        bit [DW-1:0] rdata;
        bit          err;
        int          acc;
    } rsp_t;

    txn_t slv_q[$];
    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   rsp_count = 0;
    int   last_acc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: pops a transaction at SETUP, holds PREADY low for 'waits' ACCESS cycles.
    txn_t cur;
    bit   active = 0;
    int   acc = 0;

    task automatic chk_fields(string ph);
        chk({ph, "_pwrite"}, PWRITE, cur.write);
        chk({ph, "_paddr"}, PADDR, cur.addr);
        chk({ph, "_pwdata"}, PWDATA, cur.write ? cur.wdata : '0);
        chk({ph, "_pstrb"}, PSTRB, cur.write ? cur.strb : '0);
    endtask

    always @(negedge PCLK) begin
        if (PRESET) begin
            active  = 0;
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end else if (PSEL && !PENABLE) begin
            if (slv_q.size() == 0) begin
                chk("setup_unexpected", 1, 0);
            end else begin
                cur    = slv_q.pop_front();
                active = 1;
                acc    = 0;
                chk_fields("setup");
            end
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end else if (PSEL && PENABLE) begin
            if (!active) begin
                chk("access_without_setup", 1, 0);
            end else begin
                acc++;
                last_acc = acc;
                chk_fields("access");
                if (acc == cur.waits + 1) begin
                    PREADY  = 1'b1;
                    PRDATA  = cur.prdata;
                    PSLVERR = cur.err;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom);
                end
            end
        end else begin
            active  = 0;
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end
    end

    // Response monitor
    logic [DW-1:0] hold_rdata = '0;
    logic          hold_err = 1'b0;

    always @(negedge PCLK) begin
        if (PRESET) begin
            hold_rdata = '0;
            hold_err   = 1'b0;
        end else if (rsp_valid) begin
            rsp_t e;
            rsp_count++;
            chk("ready_with_rsp", cmd_ready, 1);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("penable_cycles", last_acc, e.acc);
                hold_rdata = e.rdata;
                hold_err   = e.err;
            end
        end else begin
            chk("rsp_rdata_hold", rsp_rdata, hold_rdata);
            chk("rsp_err_hold", rsp_err, hold_err);
        end
    end

    task automatic issue(txn_t t, bit exp_rsp);
        int guard = 0;
        rsp_t e;
        slv_q.push_back(t);
        if (exp_rsp) begin
            e.rdata = t.write ? '0 : t.prdata;
            e.err   = t.err;
            e.acc   = t.waits + 1;
            exp_q.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_strb  = t.strb;
        while (!cmd_ready && guard < 300) begin
            @(negedge PCLK);
            guard++;
        end
        if (guard >= 300) chk("cmd_accept_timeout", guard, 0);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        cmd_addr  = AW'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge PCLK);
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge PCLK);
    endtask

    function automatic txn_t mk(bit w, int a, logic [DW-1:0] wd, int s, int wt, logic [DW-1:0] rd, bit er);
        txn_t t;
        t.write = w; t.addr = AW'(a); t.wdata = wd; t.strb = SW'(s);
        t.waits = wt; t.prdata = rd; t.err = er;
        return t;
    endfunction

    initial begin
        txn_t t;
        int   start, guard;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pstrb", PSTRB, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("ready_after_reset", cmd_ready, 1);

        issue(mk(1, 1, 32'hFFFF_FFFF, 4'hF, 0, 32'h1234_5678, 0), 1);
        drain();
        issue(mk(0, 2, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0100, 0), 1);
        drain();
        issue(mk(1, 5, 32'hA5A5_5A5A, 4'h3, 3, 32'h0, 0), 1);
        drain();
        issue(mk(1, 7, 32'h0BAD_F00D, 4'h9, 1, 32'h0, 1), 1);
        issue(mk(0, 3, 32'h0, 4'h0, 0, 32'hCAFE_0001, 0), 1);
        drain();

        // reset in the middle of ACCESS
        issue(mk(1, 4, 32'h1111_2222, 4'hC, 5, 32'h0, 0), 0);
        guard = 0;
        while (!(PSEL && PENABLE) && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        chk("reach_access", PSEL && PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("abort_psel", PSEL, 0);
        chk("abort_penable", PENABLE, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("ready_after_abort", cmd_ready, 1);
        repeat (3) @(negedge PCLK);

        for (int i = 0; i < 200; i++) begin
            t = mk(1'($urandom), int'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 4)), $urandom, 1'($urandom));
            issue(t, 1);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        drain();

        start = rsp_count;
`ifdef APB_TIMEOUT_EN
        t = mk(0, 9, 32'h0, 4'h0, 100000, 32'hFFFF_0000, 0);
        issue(t, 0);
        begin
            rsp_t e;
            e.rdata = '0; e.err = 1'b1; e.acc = TO;
            exp_q.push_back(e);
        end
        drain();
        chk("timeout_rsp_count", rsp_count, start + 1);
`else
        t = mk(1, 9, 32'h5555_AAAA, 4'hF, 100000, 32'h0, 0);
        issue(t, 0);
        repeat (100) @(negedge PCLK);
        chk("no_rsp_without_timeout", rsp_count, start);
        chk("still_in_access", PSEL && PENABLE, 1);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
`endif
        issue(mk(0, 6, 32'h0, 4'h0, 2, 32'h0F0F_F0F0, 0), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
